// File: rtl/chrom_eval_dispatcher_pkg.sv
// Shared definitions for the chromosome evaluation dispatcher: state encoding
// and default geometry of a chromosome and its result block.
package chrom_eval_dispatcher_pkg;

   localparam int CHROM_WORDS_DEF = 31;
   localparam int NUM_SUMS_DEF    = 8;
   localparam int CHROM_STRIDE    = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH      = 3'd1,
      ST_WAIT_READY = 3'd2,
      ST_START      = 3'd3,
      ST_FEEDBACK   = 3'd4,
      ST_WRITEBACK  = 3'd5,
      ST_NEXT       = 3'd6
   } disp_state_t;

endpackage

// File: rtl/chrom_eval_dispatcher_assembler.sv
// Shifts fetched RAM words into the chromosome description register; after
// WORDS captures the first word fetched sits in bits [31:0].
module chrom_word_assembler
   import chrom_eval_dispatcher_pkg::*;
#(
   parameter int WORDS = CHROM_WORDS_DEF
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  capture,
   input  logic [31:0]           word,
   output logic [WORDS*32-1:0]   description
);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         description <= '0;
      end else if (capture) begin
         description <= {word, description[WORDS*32-1:32]};
      end
   end

endmodule

// File: rtl/chrom_eval_dispatcher.sv
// Batch dispatcher: fetches each chromosome from RAM, hands it to the
// evaluator via a start/done/feedback handshake and writes the error sums back.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for iGo
// FETCH       | issuing CHROM_WORDS reads, capturing one cycle later
// WAIT_READY  | description assembled, waiting for evaluator ready
// START       | oStartProcessing high until iDoneProcessing seen
// FEEDBACK    | oDoneProcessingFeedback high until iDoneProcessing drops
// WRITEBACK   | NUM_SUMS consecutive result writes
// NEXT        | advance to next chromosome or finish the batch
module chrom_eval_dispatcher
   import chrom_eval_dispatcher_pkg::*;
#(
   parameter int CHROM_WORDS = CHROM_WORDS_DEF,
   parameter int NUM_SUMS    = NUM_SUMS_DEF,
   parameter int ADDR_W      = 16
) (
   input  logic                      iClock,
   input  logic                      iReset,
   input  logic                      iGo,
   input  logic [15:0]               iNumChroms,
   input  logic [ADDR_W-1:0]         iChromBase,
   input  logic [ADDR_W-1:0]         iResultBase,
   output logic [ADDR_W-1:0]         oMemAddress,
   output logic                      oMemWrite,
   output logic [31:0]               oMemWriteData,
   input  logic [31:0]               iMemReadData,
   output logic [CHROM_WORDS*32-1:0] oChromDescription,
   output logic                      oStartProcessing,
   input  logic                      iReadyToProcess,
   input  logic                      iDoneProcessing,
   output logic                      oDoneProcessingFeedback,
   input  logic [NUM_SUMS*32-1:0]    iErrorSums,
   output logic                      oBusy,
   output logic                      oBatchDone,
   output logic [15:0]               oChromIndex,
   output logic [2:0]                oState
);

   localparam int FCNT_W = $clog2(CHROM_WORDS + 1);
   localparam int WCNT_W = $clog2(NUM_SUMS + 1);

   localparam logic [FCNT_W-1:0] FETCH_LOAD = FCNT_W'(CHROM_WORDS);
   localparam logic [FCNT_W-1:0] FETCH_ONE  = FCNT_W'(1);
   localparam logic [WCNT_W-1:0] WB_LOAD    = WCNT_W'(NUM_SUMS - 1);
   localparam logic [WCNT_W-1:0] WB_ONE     = WCNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(CHROM_STRIDE);
   localparam logic [ADDR_W-1:0] SUMS_A     = ADDR_W'(NUM_SUMS);

   disp_state_t               state;
   logic [15:0]               num_q;
   logic [ADDR_W-1:0]         chrom_ptr;
   logic [ADDR_W-1:0]         result_ptr;
   logic [FCNT_W-1:0]         fetch_cnt;
   logic [WCNT_W-1:0]         wb_cnt;
   logic                      rd_pending;
   logic [NUM_SUMS*32-1:0]    sums_q;

   assign oState = state;

   // rd_pending marks that the previous cycle issued a read, so this
   // cycle's iMemReadData holds the next chromosome word.
   chrom_word_assembler #(
      .WORDS (CHROM_WORDS)
   ) u_assembler (
      .iClock      (iClock),
      .iReset      (iReset),
      .capture     (rd_pending),
      .word        (iMemReadData),
      .description (oChromDescription)
   );

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state                   <= ST_IDLE;
         num_q                   <= '0;
         chrom_ptr               <= '0;
         result_ptr              <= '0;
         fetch_cnt               <= '0;
         wb_cnt                  <= '0;
         rd_pending              <= 1'b0;
         sums_q                  <= '0;
         oMemAddress             <= '0;
         oMemWrite               <= 1'b0;
         oMemWriteData           <= '0;
         oStartProcessing        <= 1'b0;
         oDoneProcessingFeedback <= 1'b0;
         oBusy                   <= 1'b0;
         oBatchDone              <= 1'b0;
         oChromIndex             <= '0;
      end else begin
         oBatchDone <= 1'b0;
         rd_pending <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iGo) begin
                  if (iNumChroms == 16'd0) begin
                     oBatchDone <= 1'b1;
                  end else begin
                     num_q       <= iNumChroms;
                     chrom_ptr   <= iChromBase;
                     result_ptr  <= iResultBase;
                     oChromIndex <= '0;
                     oMemAddress <= iChromBase;
                     fetch_cnt   <= FETCH_LOAD;
                     oBusy       <= 1'b1;
                     state       <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               // Down-counter: CHROM_WORDS issue cycles, then one drain
               // cycle in which the final word is captured.
               if (fetch_cnt == '0) begin
                  state <= ST_WAIT_READY;
               end else begin
                  rd_pending <= 1'b1;
                  fetch_cnt  <= fetch_cnt - FETCH_ONE;
                  if (fetch_cnt != FETCH_ONE) begin
                     oMemAddress <= oMemAddress + ADDR_ONE;
                  end
               end
            end
            ST_WAIT_READY: begin
               if (iReadyToProcess) begin
                  oStartProcessing <= 1'b1;
                  state            <= ST_START;
               end
            end
            ST_START: begin
               if (iDoneProcessing) begin
                  sums_q                  <= iErrorSums;
                  oStartProcessing        <= 1'b0;
                  oDoneProcessingFeedback <= 1'b1;
                  state                   <= ST_FEEDBACK;
               end
            end
            ST_FEEDBACK: begin
               if (!iDoneProcessing) begin
                  oDoneProcessingFeedback <= 1'b0;
                  oMemWrite               <= 1'b1;
                  oMemAddress             <= result_ptr;
                  oMemWriteData           <= sums_q[31:0];
                  sums_q                  <= sums_q >> 32;
                  wb_cnt                  <= WB_LOAD;
                  state                   <= ST_WRITEBACK;
               end
            end
            ST_WRITEBACK: begin
               if (wb_cnt == '0) begin
                  oMemWrite <= 1'b0;
                  state     <= ST_NEXT;
               end else begin
                  oMemAddress   <= oMemAddress + ADDR_ONE;
                  oMemWriteData <= sums_q[31:0];
                  sums_q        <= sums_q >> 32;
                  wb_cnt        <= wb_cnt - WB_ONE;
               end
            end
            ST_NEXT: begin
               if (oChromIndex == num_q - 16'd1) begin
                  oBatchDone <= 1'b1;
                  oBusy      <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  oChromIndex <= oChromIndex + 16'd1;
                  chrom_ptr   <= chrom_ptr + STRIDE_A;
                  oMemAddress <= chrom_ptr + STRIDE_A;
                  result_ptr  <= result_ptr + SUMS_A;
                  fetch_cnt   <= FETCH_LOAD;
                  state       <= ST_FETCH;
               end
            end
            default: begin
               oBusy <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
